cfg_loader: RTL and testbench

Serial configuration loader for the DRSSTC controller. It receives framed byte commands from the host byte link through a valid/ready handshake and validates each frame. Each accepted frame becomes exactly one write strobe on the shared parameter bus (`addr`/`shift`/`en`) that feeds the addressable timing blocks (predictor, dead-time, limits). Writes are held off while a burst is active, so a register never changes mid-burst.

---
 rtl/cfg_loader_pkg.sv | 23 ++
 rtl/cfg_frame_rx.sv | 97 +++++++++
 rtl/cfg_loader.sv | 97 +++++++++
 tb/tb_cfg_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared constants, state encoding and width helpers for the configuration loader.
package cfg_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_GET_CHK  = 3'd3,
        ST_COMMIT   = 3'd4
    } cfg_state_e;

    // Bits needed to hold max_val (at least one).
    function automatic int unsigned bits_for(input int unsigned max_val);
        return (max_val < 32'd2) ? 32'd1 : $clog2(max_val + 32'd1);
    endfunction

    function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
        return addr + data;
    endfunction

endpackage

// File: rtl/cfg_frame_rx.sv
// Byte-level frame receiver: SYNC/ADDR/DATA/CHK FSM, inter-byte timeout and
// frame validation. Emits a one-cycle valid or error indication per frame.
module cfg_frame_rx
    import cfg_loader_pkg::*;
#(
    parameter int unsigned DATA_MAX = 255,
    parameter int unsigned ADDR_MAX = 4,
    parameter int unsigned TIMEOUT  = 1000,
    localparam int unsigned DW = bits_for(DATA_MAX),
    localparam int unsigned AW = bits_for(ADDR_MAX),
    localparam int unsigned TW = bits_for(TIMEOUT)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [7:0]    byte_data_i,
    input  logic          byte_fire_i,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o,
    output logic          frame_valid_o,
    output logic          frame_err_o
);

    cfg_state_e    state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // Frame FSM, timeout counter and validation.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        tmo_d         = tmo_q;
        frame_valid_o = 1'b0;
        frame_err_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (byte_fire_i && (byte_data_i == SYNC_BYTE)) begin
                    state_d = ST_GET_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_ADDR, ST_GET_DATA, ST_GET_CHK: begin
                if (byte_fire_i) begin
                    tmo_d = '0;
                    if (state_q == ST_GET_ADDR) begin
                        addr_d  = byte_data_i;
                        state_d = ST_GET_DATA;
                    end else if (state_q == ST_GET_DATA) begin
                        data_d  = byte_data_i;
                        state_d = ST_GET_CHK;
                    end else begin
                        state_d = ST_IDLE;
                        if ((byte_data_i == frame_chk(addr_q, data_q)) &&
                            (addr_q <= 8'(ADDR_MAX)) && (data_q <= 8'(DATA_MAX))) begin
                            frame_valid_o = 1'b1;
                        end else begin
                            frame_err_o = 1'b1;
                        end
                    end
                end else if (tmo_q >= TW'(TIMEOUT - 32'd1)) begin
                    // TIMEOUT idle cycles have now elapsed since the last byte.
                    tmo_d       = '0;
                    frame_err_o = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    // State and frame field registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end

    assign addr_o = addr_q[AW-1:0];
    assign data_o = data_q[DW-1:0];

endmodule

// File: rtl/cfg_loader.sv
// Serial configuration loader: validated frames are held until the burst ends,
// then written to the parameter bus as a single registered strobe.
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int unsigned DATA_MAX = 255,
    parameter int unsigned ADDR_MAX = 4,
    parameter int unsigned TIMEOUT  = 1000,
    localparam int unsigned DW = bits_for(DATA_MAX),
    localparam int unsigned AW = bits_for(ADDR_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    byte_data,
    input  logic          byte_valid,
    output logic          byte_ready,
    input  logic          busy,
    output logic [AW-1:0] cfg_addr,
    output logic [DW-1:0] cfg_data,
    output logic          cfg_en,
    output logic          err
);

    logic          pending_q, pending_d;
    logic [AW-1:0] cfg_addr_q, cfg_addr_d;
    logic [DW-1:0] cfg_data_q, cfg_data_d;
    logic          cfg_en_q, cfg_en_d;
    logic          err_q, ready_q;
    logic          byte_fire_s, frame_valid_s, frame_err_s;
    logic [AW-1:0] rx_addr_s;
    logic [DW-1:0] rx_data_s;

    assign byte_fire_s = byte_valid && ready_q;

    cfg_frame_rx #(
        .DATA_MAX (DATA_MAX),
        .ADDR_MAX (ADDR_MAX),
        .TIMEOUT  (TIMEOUT)
    ) u_rx (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .byte_data_i   (byte_data),
        .byte_fire_i   (byte_fire_s),
        .addr_o        (rx_addr_s),
        .data_o        (rx_data_s),
        .frame_valid_o (frame_valid_s),
        .frame_err_o   (frame_err_s)
    );

    // Commit hold: the receiver keeps its fields stable because no byte is accepted while pending.
    always_comb begin
        pending_d  = pending_q;
        cfg_addr_d = cfg_addr_q;
        cfg_data_d = cfg_data_q;
        cfg_en_d   = 1'b0;
        if (pending_q) begin
            if (!busy) begin
                pending_d  = 1'b0;
                cfg_en_d   = 1'b1;
                cfg_addr_d = rx_addr_s;
                cfg_data_d = rx_data_s;
            end else begin
                pending_d = 1'b1;
            end
        end else if (frame_valid_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = 1'b0;
        end
    end

    // Output bus, strobes and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= 1'b0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
            cfg_en_q   <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            cfg_en_q   <= cfg_en_d;
            err_q      <= frame_err_s;
            ready_q    <= !pending_d;
        end
    end

    assign byte_ready = ready_q;
    assign cfg_addr   = cfg_addr_q;
    assign cfg_data   = cfg_data_q;
    assign cfg_en     = cfg_en_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cfg_loader.sv
// Directed self-checking bench for cfg_loader with default parameters.
module tb_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       busy;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_en;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_en     (cfg_en),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following the transfer.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_bound", 32'(n < 100), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    initial begin
        int viol;
        int cyc;
        rst_n      = 1'b0;
        busy       = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_en", 32'(cfg_en), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(cfg_addr), 32'd0);
        chk("rst_data", 32'(cfg_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(byte_ready), 32'd1);

        // Good frame A5 02 40 42
        send(8'hA5); send(8'h02); send(8'h40); send(8'h42);
        chk("good_err_k", 32'(err), 32'd0);
        chk("good_en_k", 32'(cfg_en), 32'd0);
        chk("good_ready_commit", 32'(byte_ready), 32'd0);
        @(negedge clk);
        chk("good_en_k1", 32'(cfg_en), 32'd1);
        chk("good_addr", 32'(cfg_addr), 32'd2);
        chk("good_data", 32'(cfg_data), 32'h40);
        chk("good_err_k1", 32'(err), 32'd0);
        chk("good_ready_back", 32'(byte_ready), 32'd1);
        @(negedge clk);
        chk("good_en_k2", 32'(cfg_en), 32'd0);
        chk("good_addr_hold", 32'(cfg_addr), 32'd2);

        // Bad checksum A5 02 40 43
        send(8'hA5); send(8'h02); send(8'h40); send(8'h43);
        chk("badchk_err", 32'(err), 32'd1);
        chk("badchk_en", 32'(cfg_en), 32'd0);
        @(negedge clk);
        chk("badchk_err_1cyc", 32'(err), 32'd0);
        chk("badchk_en_after", 32'(cfg_en), 32'd0);
        chk("badchk_addr_hold", 32'(cfg_addr), 32'd2);
        chk("badchk_data_hold", 32'(cfg_data), 32'h40);

        // Following good frame A5 01 10 11
        send(8'hA5); send(8'h01); send(8'h10); send(8'h11);
        chk("good2_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("good2_en", 32'(cfg_en), 32'd1);
        chk("good2_addr", 32'(cfg_addr), 32'd1);
        chk("good2_data", 32'(cfg_data), 32'h10);
        @(negedge clk);

        // Address out of range A5 05 10 15
        send(8'hA5); send(8'h05); send(8'h10); send(8'h15);
        chk("addr_oor_err", 32'(err), 32'd1);
        chk("addr_oor_ready", 32'(byte_ready), 32'd1);
        @(negedge clk);
        chk("addr_oor_en", 32'(cfg_en), 32'd0);
        chk("addr_oor_addr_hold", 32'(cfg_addr), 32'd1);

        // Boundary: ADDR_MAX, DATA_MAX, wrapping checksum A5 04 FF 03
        send(8'hA5); send(8'h04); send(8'hFF); send(8'h03);
        chk("max_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("max_en", 32'(cfg_en), 32'd1);
        chk("max_addr", 32'(cfg_addr), 32'd4);
        chk("max_data", 32'(cfg_data), 32'hFF);
        @(negedge clk);

        // Busy hold: A5 03 20 23 completes while busy=1 for 50 cycles
        busy = 1'b1;
        send(8'hA5); send(8'h03); send(8'h20); send(8'h23);
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            if (byte_ready !== 1'b0 || cfg_en !== 1'b0 || err !== 1'b0) viol++;
            @(negedge clk);
        end
        chk("busy_hold_violations", 32'(viol), 32'd0);
        chk("busy_hold_addr_old", 32'(cfg_addr), 32'd4);
        busy = 1'b0;
        @(negedge clk);
        chk("busy_release_en", 32'(cfg_en), 32'd1);
        chk("busy_release_addr", 32'(cfg_addr), 32'd3);
        chk("busy_release_data", 32'(cfg_data), 32'h20);
        @(negedge clk);
        chk("busy_release_en_off", 32'(cfg_en), 32'd0);

        // Timeout after A5 01
        send(8'hA5); send(8'h01);
        cyc = 0;
        while (!err && cyc < 1100) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_err_seen", 32'(err), 32'd1);
        chk("tmo_not_early", 32'(cyc >= 1000), 32'd1);
        chk("tmo_not_late", 32'(cyc <= 1001), 32'd1);
        @(negedge clk);
        chk("tmo_err_1cyc", 32'(err), 32'd0);
        // If 0x01 were not discarded, 01 02 03 would form a valid frame.
        send(8'h01); send(8'h02); send(8'h03);
        viol = 0;
        for (int i = 0; i < 3; i++) begin
            if (cfg_en !== 1'b0 || err !== 1'b0) viol++;
            @(negedge clk);
        end
        chk("tmo_discard_quiet", 32'(viol), 32'd0);
        chk("tmo_discard_addr", 32'(cfg_addr), 32'd3);

        // Reset while in COMMIT
        busy = 1'b1;
        send(8'hA5); send(8'h02); send(8'h55); send(8'h57);
        chk("rstc_ready_commit", 32'(byte_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstc_addr", 32'(cfg_addr), 32'd0);
        chk("rstc_data", 32'(cfg_data), 32'd0);
        chk("rstc_ready", 32'(byte_ready), 32'd0);
        chk("rstc_en", 32'(cfg_en), 32'd0);
        @(negedge clk);
        busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cfg_en !== 1'b0 || err !== 1'b0) viol++;
        end
        chk("rstc_no_strobe", 32'(viol), 32'd0);
        chk("rstc_addr_after", 32'(cfg_addr), 32'd0);
        chk("rstc_ready_after", 32'(byte_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
